// File: rtl/lms_stream_sequencer.sv
// Sequencer that loads the LMS reciprocal LUT, then streams u/e samples round-robin per tick.
// Optional underrun counter enabled by defining LMS_SEQ_UNDERRUN_CNT_EN.
module lms_stream_sequencer #(
  parameter int CH       = 1,
  parameter int U_W      = 32,
  parameter int E_W      = 32,
  parameter int LUT_SIZE = 128,
  parameter int LUT_W    = 12,
  parameter int CNT_W    = 16,
  localparam int LUT_IDX_W = $clog2(LUT_SIZE),
  localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      period,
  input  logic [CNT_W-1:0]      num_samples,
  output logic [LUT_IDX_W-1:0]  lut_rd_addr,
  input  logic [LUT_W-1:0]      lut_rd_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic signed [U_W-1:0] src_u,
  input  logic signed [E_W-1:0] src_e,
  output logic                  write_lut_in,
  output logic [LUT_IDX_W-1:0]  write_lut_idx,
  output logic [LUT_W-1:0]      write_lut_data,
  output logic                  valid_u_in,
  output logic                  valid_e_in,
  output logic signed [U_W-1:0] data_u_in,
  output logic signed [E_W-1:0] data_e_in,
  output logic [CH_W-1:0]       ch_sel,
  input  logic                  valid_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      out_cnt,
  output logic [CNT_W-1:0]      underrun_cnt,
  output logic [2:0]            state_dbg
);

  localparam int LW1 = LUT_IDX_W + 1;
  localparam logic [LW1-1:0] LUT_END = LW1'(LUT_SIZE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LUT_LOAD = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      per_q, ns_q, tcnt, tick_cnt, out_cnt_q, out_cnt_nxt, keff;
  logic [LW1-1:0]        lut_cnt;
  logic                  run_start, lut_issue, slot_active, xfer, last_slot, out_inc;
  logic                  wr_q, vld_q;
  logic [LUT_IDX_W-1:0]  wr_idx_q;
  logic signed [U_W-1:0] du_q;
  logic signed [E_W-1:0] de_q;
  logic [CH_W-1:0]       ch_q;

  // Slots occupy tick-counter values 0..CH-1; Keff >= CH guarantees they fit in one period.
  always_comb begin
    keff        = (per_q < CNT_W'(CH)) ? CNT_W'(CH) : per_q;
    run_start   = (state == IDLE) && start;
    lut_issue   = (state == LUT_LOAD) && (lut_cnt < LUT_END);
    slot_active = (state == STREAM) && (tcnt < CNT_W'(CH));
    xfer        = slot_active && src_valid;
    last_slot   = (tcnt == CNT_W'(CH - 1));
    out_inc     = valid_out && ((state == STREAM) || (state == DRAIN)) && (out_cnt_q != '1);
    out_cnt_nxt = out_inc ? out_cnt_q + CNT_W'(1) : out_cnt_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = LUT_LOAD;
      LUT_LOAD: if (lut_cnt == LUT_END) state_nxt = (ns_q == '0) ? DONE : STREAM;
      STREAM:   if (xfer && last_slot && (tick_cnt == ns_q - CNT_W'(1))) state_nxt = DRAIN;
      DRAIN:    if (out_cnt_nxt >= ns_q) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      per_q     <= '0;
      ns_q      <= '0;
      tcnt      <= '0;
      tick_cnt  <= '0;
      out_cnt_q <= '0;
      lut_cnt   <= '0;
      wr_q      <= 1'b0;
      wr_idx_q  <= '0;
      vld_q     <= 1'b0;
      du_q      <= '0;
      de_q      <= '0;
      ch_q      <= '0;
    end else begin
      out_cnt_q <= out_cnt_nxt;
      if (lut_issue) lut_cnt <= lut_cnt + LW1'(1);
      wr_q     <= lut_issue;
      wr_idx_q <= lut_issue ? lut_cnt[LUT_IDX_W-1:0] : '0;
      // A slot waiting on src_valid freezes the tick counter so later ticks shift.
      if ((state == STREAM) && !(slot_active && !src_valid))
        tcnt <= (tcnt >= keff - CNT_W'(1)) ? '0 : tcnt + CNT_W'(1);
      if (xfer && last_slot) tick_cnt <= tick_cnt + CNT_W'(1);
      vld_q <= xfer;
      du_q  <= xfer ? src_u : '0;
      de_q  <= xfer ? src_e : '0;
      ch_q  <= xfer ? CH_W'(tcnt) : '0;
      if (run_start) begin
        per_q     <= period;
        ns_q      <= num_samples;
        out_cnt_q <= '0;
        lut_cnt   <= '0;
        tcnt      <= '0;
        tick_cnt  <= '0;
      end
    end
  end

`ifdef LMS_SEQ_UNDERRUN_CNT_EN
  logic             stall_q;
  logic [CNT_W-1:0] und_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q <= 1'b0;
      und_q   <= '0;
    end else begin
      stall_q <= slot_active && !src_valid;
      if (run_start)
        und_q <= '0;
      else if (slot_active && !src_valid && !stall_q && (und_q != '1))
        und_q <= und_q + CNT_W'(1);
    end
  end

  assign underrun_cnt = und_q;
`else
  assign underrun_cnt = '0;
`endif

  assign lut_rd_addr    = lut_issue ? lut_cnt[LUT_IDX_W-1:0] : '0;
  assign src_ready      = slot_active;
  assign write_lut_in   = wr_q;
  assign write_lut_idx  = wr_idx_q;
  assign write_lut_data = wr_q ? lut_rd_data : '0;
  assign valid_u_in     = vld_q;
  assign valid_e_in     = vld_q;
  assign data_u_in      = du_q;
  assign data_e_in      = de_q;
  assign ch_sel         = ch_q;
  assign busy           = (state == LUT_LOAD) || (state == STREAM) || (state == DRAIN);
  assign done           = (state == DONE);
  assign out_cnt        = out_cnt_q;
  assign state_dbg      = state;

endmodule

// File: doc/lms_stream_sequencer.md
LMS_STREAM_SEQUENCER -- requirements
Module: lms_stream_sequencer

Interface
REQ-001 Param CH, default 1: channels served per sample tick, round-robin.
REQ-002 Param U_W, default 32: u sample width (signed); param E_W, default 32: e sample width (signed).
REQ-003 Param LUT_SIZE, default 128: reciprocal LUT entries; param LUT_W, default 12: LUT word width; LUT_IDX_W = $clog2(LUT_SIZE).
REQ-004 Param CNT_W, default 16: width of sample and output counters and of the period input.
REQ-005 clock  in  1  sole clock, rising edge; reset  in  1  synchronous, active-low.
REQ-006 start  in  1  one-cycle pulse, begins a run; period  in  CNT_W  clocks between sample ticks (K); num_samples  in  CNT_W  ticks per run.
REQ-007 lut_rd_addr  out  LUT_IDX_W  source-LUT read address; lut_rd_data  in  LUT_W  source data, valid one cycle after address.
REQ-008 src_valid  in  1 / src_ready  out  1 / src_u  in  U_W / src_e  in  E_W  sample source handshake, transfer when both high.
REQ-009 write_lut_in  out  1 / write_lut_idx  out  LUT_IDX_W / write_lut_data  out  LUT_W  LUT programming port to LMS.
REQ-010 valid_u_in, valid_e_in  out  1 / data_u_in  out  U_W / data_e_in  out  E_W / ch_sel  out  $clog2(CH) (min 1)  sample port to LMS.
REQ-011 valid_out  in  1  LMS result strobe; busy  out  1; done  out  1; out_cnt  out  CNT_W; underrun_cnt  out  CNT_W.

Function
REQ-012 FSM states IDLE, LUT_LOAD, STREAM, DRAIN, DONE; IDLE->LUT_LOAD on start; start ignored in any other state.
REQ-013 LUT_LOAD: lut_rd_addr steps 0..LUT_SIZE-1, one per cycle; write_lut_in high for exactly LUT_SIZE cycles, one cycle after each address, with write_lut_idx = that address, write_lut_data = lut_rd_data.
REQ-014 LUT_LOAD->STREAM the cycle after the last LUT write; if num_samples == 0, go to DONE instead.
REQ-015 STREAM: tick counter counts 0..Keff-1, Keff = max(period, CH); period 0 treated as CH; tick occurs at count 0, first tick on first STREAM cycle.
REQ-016 At each tick, CH consecutive source transfers; each drives valid_u_in=valid_e_in=1 for one cycle with registered src_u/src_e and ch_sel = 0..CH-1; src_ready high only in those slots.
REQ-017 If src_valid low in a slot, slot stalls (tick counter held, valid_* low) until src_valid high; no data skipped or duplicated.
REQ-018 data_u_in/data_e_in = 0 whenever valid_* low.
REQ-019 After num_samples ticks fully transferred, STREAM->DRAIN.
REQ-020 out_cnt increments on each valid_out in STREAM or DRAIN, saturating at all-ones; DRAIN->DONE when out_cnt == num_samples.
REQ-021 DONE: done high one cycle, then IDLE; busy high in LUT_LOAD, STREAM, DRAIN.
REQ-022 out_cnt and underrun_cnt cleared on accepted start, held otherwise.
REQ-023 valid_out in IDLE or LUT_LOAD ignored.

Reset
REQ-024 reset low at a rising edge: state IDLE; all outputs 0 (busy, done, src_ready, write_lut_in, valid_*, data_*, addr/idx, ch_sel, counters) on next cycle.
REQ-025 reset mid-run aborts immediately, no further LUT writes or sample strobes; a start in the same cycle as reset is ignored.

Configuration
REQ-026 Macro LMS_SEQ_UNDERRUN_CNT_EN defined: underrun_cnt increments once per stalled slot (first stall cycle only), saturating.
REQ-027 Macro undefined: underrun_cnt tied to 0, no counter logic; all else identical.

Verification
REQ-028 LUT_SIZE=128, source LUT[i]=i^0x5A5 -> 128 writes, idx 0..127, data matches, none duplicated, STREAM entered 129 cycles after start.
REQ-029 CH=1, period=32, num_samples=4, src_valid=1 -> valid_u_in pulses exactly 32 cycles apart, data in source order; 4 valid_out -> done one cycle after 4th.
REQ-030 CH=4, period=2 -> Keff=4, strobes every cycle, ch_sel 0,1,2,3 repeating.
REQ-031 src_valid low 5 cycles at tick 2 -> tick 2 delayed 5 cycles, later ticks shifted; underrun_cnt=1 with macro, 0 without.
REQ-032 num_samples=0 -> LUT load completes, done asserted, zero sample strobes.
REQ-033 reset low during STREAM tick 3 -> all outputs 0 next cycle; new start re-runs LUT load from idx 0.
